// File: rtl/tri_fetcher.sv
// Triangle fetcher: reads three vertex words per triangle, offsets and clamps x/y,
// then offers the triangle to the rasterizer with a valid/ready handshake.
module tri_fetcher #(
   parameter int unsigned WIDTH       = 240,
   parameter int unsigned HEIGHT      = 240,
   parameter int unsigned NUM_TRIS    = 12,
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              new_frame,
   input  logic              ready_in,
   input  logic [8:0]        x_off,
   input  logic [8:0]        y_off,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [26:0]       mem_data,
   output logic [2:0][8:0]   vert1,
   output logic [2:0][8:0]   vert2,
   output logic [2:0][8:0]   vert3,
   output logic              valid_tri,
   output logic              obj_done,
   output logic              busy,
   output logic              frame_done
);

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OFFER, HOLD} state_t;

   localparam logic [9:0]        X_MAX    = 10'(WIDTH - 1);
   localparam logic [9:0]        Y_MAX    = 10'(HEIGHT - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TRIS - 1);

   state_t                 state;
   logic [ADDR_W-1:0]      tri_idx;
   logic [ADDR_W-1:0]      base;
   logic [1:0]             k;
   logic                   hold_wait;
   logic [MEM_LATENCY-1:0] tag_v;
   logic [1:0]             tag_k [MEM_LATENCY];
   logic [9:0]             x_sum;
   logic [9:0]             y_sum;
   logic [2:0][8:0]        word;

   always_comb begin
      x_sum   = {1'b0, mem_data[26:18]} + {1'b0, x_off};
      y_sum   = {1'b0, mem_data[17:9]} + {1'b0, y_off};
      word[2] = (x_sum > X_MAX) ? X_MAX[8:0] : x_sum[8:0];
      word[1] = (y_sum > Y_MAX) ? Y_MAX[8:0] : y_sum[8:0];
      word[0] = mem_data[8:0];
   end

   // Tags ride alongside the memory pipeline so each returning word lands in its vertex slot.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         tag_v <= '0;
         for (int i = 0; i < MEM_LATENCY; i++) tag_k[i] <= 2'd0;
      end else begin
         tag_v[0] <= (state == FETCH);
         tag_k[0] <= k;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_k[i] <= tag_k[i-1];
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         vert1 <= '0;
         vert2 <= '0;
         vert3 <= '0;
      end else if (tag_v[MEM_LATENCY-1]) begin
         case (tag_k[MEM_LATENCY-1])
            2'd0:    vert1 <= word;
            2'd1:    vert2 <= word;
            default: vert3 <= word;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state      <= IDLE;
         tri_idx    <= '0;
         base       <= '0;
         k          <= 2'd0;
         hold_wait  <= 1'b0;
         mem_addr   <= '0;
         valid_tri  <= 1'b0;
         obj_done   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (new_frame) begin
                  state    <= FETCH;
                  tri_idx  <= '0;
                  base     <= '0;
                  mem_addr <= '0;
                  k        <= 2'd0;
                  busy     <= 1'b1;
               end
            end
            FETCH: begin
               if (k == 2'd2) begin
                  state <= DRAIN;
               end else begin
                  k        <= k + 2'd1;
                  mem_addr <= mem_addr + ADDR_W'(1);
               end
            end
            DRAIN: begin
               // Leave once the third word is being captured this very edge.
               if (tag_v[MEM_LATENCY-1] && tag_k[MEM_LATENCY-1] == 2'd2) begin
                  state     <= OFFER;
                  valid_tri <= 1'b1;
                  obj_done  <= (tri_idx == LAST_IDX);
               end
            end
            OFFER: begin
               if (ready_in) begin
                  state     <= HOLD;
                  valid_tri <= 1'b0;
                  obj_done  <= 1'b0;
                  hold_wait <= 1'b1;
               end
            end
            HOLD: begin
               // First HOLD cycle ignores ready: the rasterizer lowers it one cycle late.
               if (hold_wait) begin
                  hold_wait <= 1'b0;
               end else if (ready_in) begin
                  if (tri_idx == LAST_IDX) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                  end else begin
                     state    <= FETCH;
                     tri_idx  <= tri_idx + ADDR_W'(1);
                     base     <= base + ADDR_W'(3);
                     mem_addr <= base + ADDR_W'(3);
                     k        <= 2'd0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tri_fetcher.sv
// Bench for tri_fetcher: latency-modelled vertex memory, randomized frames checked against
// a clamp-and-offset reference model and handshake rules.
module tb_tri_fetcher;
   localparam int unsigned NT  = 2;
   localparam int unsigned LAT = 2;
   localparam int          NW  = 3 * NT;

   logic            clk = 1'b0;
   logic            rst;
   logic            new_frame;
   logic            ready;
   logic [8:0]      x_off;
   logic [8:0]      y_off;
   logic [11:0]     mem_addr;
   logic [26:0]     mem_data;
   logic [2:0][8:0] vert1;
   logic [2:0][8:0] vert2;
   logic [2:0][8:0] vert3;
   logic            valid_tri;
   logic            obj_done;
   logic            busy;
   logic            frame_done;

   logic [26:0] mem  [NW];
   logic [26:0] pipe [LAT];

   int n_cmp = 0;
   int n_err = 0;

   logic [80:0] obs_tri[$];
   bit          obs_obj[$];
   int          obs_addr[$];
   int          obs_fd;
   int          first_valid;
   logic        fd_busy;
   bit          timed_out;

   tri_fetcher #(
      .NUM_TRIS    (NT),
      .MEM_LATENCY (LAT)
   ) dut (
      .clk_in     (clk),
      .rst_in     (rst),
      .new_frame  (new_frame),
      .ready_in   (ready),
      .x_off      (x_off),
      .y_off      (y_off),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .vert1      (vert1),
      .vert2      (vert2),
      .vert3      (vert3),
      .valid_tri  (valid_tri),
      .obj_done   (obj_done),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Memory returns data MEM_LATENCY cycles after the address is presented.
   always @(posedge clk) begin
      pipe[0] <= (int'(mem_addr) < NW) ? mem[int'(mem_addr)] : '0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_data = pipe[LAT-1];

   function automatic logic [8:0] clampv(logic [8:0] v, logic [8:0] off, int lim);
      int s;
      s = int'(v) + int'(off);
      return (s > lim - 1) ? 9'(lim - 1) : 9'(s);
   endfunction

   function automatic logic [26:0] cv(logic [26:0] w);
      return {clampv(w[26:18], x_off, 240), clampv(w[17:9], y_off, 240), w[8:0]};
   endfunction

   function automatic logic [80:0] exp_tri(int t);
      return {cv(mem[3*t]), cv(mem[3*t+1]), cv(mem[3*t+2])};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem;
      for (int i = 0; i < NW; i++) begin
         mem[i] = 27'($urandom);
         if ($urandom_range(0, 3) == 0) mem[i][26:18] = 9'h1FF;
      end
      x_off = 9'($urandom);
      y_off = 9'($urandom);
   endtask

   // Runs one frame with ready tied high and records what the DUT presented.
   task automatic run_frame(input int nf_a, input int nf_b);
      int last_addr;
      int post;
      last_addr = -1;
      post      = -1;
      obs_tri.delete();
      obs_obj.delete();
      obs_addr.delete();
      obs_fd      = 0;
      first_valid = -1;
      fd_busy     = 1'b1;
      timed_out   = 1'b1;
      ready       = 1'b1;
      new_frame   = 1'b1;
      tick;
      new_frame = 1'b0;
      for (int cyc = 1; cyc < 300; cyc++) begin
         new_frame = (cyc == nf_a || cyc == nf_b);
         @(negedge clk);
         if (busy && int'(mem_addr) != last_addr) begin
            obs_addr.push_back(int'(mem_addr));
            last_addr = int'(mem_addr);
         end
         if (valid_tri && first_valid < 0) first_valid = cyc;
         if (valid_tri && ready) begin
            obs_tri.push_back({vert1, vert2, vert3});
            obs_obj.push_back(obj_done);
         end
         if (frame_done) begin
            obs_fd++;
            fd_busy = busy;
            if (post < 0) post = cyc;
         end
         tick;
         if (post >= 0 && cyc >= post + 3) begin
            timed_out = 1'b0;
            break;
         end
      end
      new_frame = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      n_cmp++;
      if ({vert1, vert2, vert3, mem_addr} !== '0) begin
         n_err++;
         $display("FAIL reset_data: got %0h want 0", {vert1, vert2, vert3, mem_addr});
      end
      n_cmp++;
      if ({valid_tri, obj_done, busy, frame_done} !== 4'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b want 0000", {valid_tri, obj_done, busy, frame_done});
      end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_basic_frame;
      bit ok;
      fill_mem();
      run_frame(-1, -1);
      n_cmp++;
      if (timed_out || obs_fd != 1) begin
         n_err++;
         $display("FAIL basic_frame_done: got %0d pulses (timeout %0d) want 1", obs_fd, timed_out);
      end
      n_cmp++;
      if (first_valid != 6) begin
         n_err++;
         $display("FAIL basic_latency: got cycle %0d want 6", first_valid);
      end
      ok = (obs_addr.size() == NW);
      for (int i = 0; i < obs_addr.size(); i++) if (obs_addr[i] != i) ok = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL basic_addr_seq: got %0d addrs %p want 0..%0d", obs_addr.size(), obs_addr,
                  NW - 1);
      end
      n_cmp++;
      if (obs_tri.size() != NT) begin
         n_err++;
         $display("FAIL basic_tri_count: got %0d want %0d", obs_tri.size(), NT);
      end
      for (int t = 0; t < obs_tri.size() && t < int'(NT); t++) begin
         n_cmp++;
         if (obs_tri[t] !== exp_tri(t)) begin
            n_err++;
            $display("FAIL basic_tri%0d: got %h want %h", t, obs_tri[t], exp_tri(t));
         end
         n_cmp++;
         if (obs_obj[t] != (t == int'(NT) - 1)) begin
            n_err++;
            $display("FAIL basic_obj_done%0d: got %0d want %0d", t, obs_obj[t], t == int'(NT) - 1);
         end
      end
      n_cmp++;
      if (fd_busy !== 1'b0) begin
         n_err++;
         $display("FAIL basic_busy_at_done: got %b want 0", fd_busy);
      end
   endtask

   task automatic test_arith;
      fill_mem();
      mem[0] = {9'd10, 9'd20, 9'd5};
      x_off  = 9'd5;
      y_off  = 9'd0;
      run_frame(-1, -1);
      n_cmp++;
      if (obs_tri.size() < 1 || obs_tri[0][80:54] !== {9'd15, 9'd20, 9'd5}) begin
         n_err++;
         $display("FAIL arith_offset: got %h want %h", obs_tri.size() ? obs_tri[0][80:54] : '0,
                  {9'd15, 9'd20, 9'd5});
      end
      mem[0] = {9'd235, 9'd230, 9'd7};
      x_off  = 9'd10;
      y_off  = 9'd300;
      run_frame(-1, -1);
      n_cmp++;
      if (obs_tri.size() < 1 || obs_tri[0][80:54] !== {9'd239, 9'd239, 9'd7}) begin
         n_err++;
         $display("FAIL arith_clamp: got %h want %h", obs_tri.size() ? obs_tri[0][80:54] : '0,
                  {9'd239, 9'd239, 9'd7});
      end
      for (int f = 0; f < 4; f++) begin
         fill_mem();
         run_frame(-1, -1);
         n_cmp++;
         if (obs_tri.size() != NT) begin
            n_err++;
            $display("FAIL arith_rand%0d_count: got %0d want %0d", f, obs_tri.size(), NT);
         end
         for (int t = 0; t < obs_tri.size() && t < int'(NT); t++) begin
            n_cmp++;
            if (obs_tri[t] !== exp_tri(t)) begin
               n_err++;
               $display("FAIL arith_rand%0d_tri%0d: got %h want %h", f, t, obs_tri[t], exp_tri(t));
            end
         end
      end
   endtask

   task automatic test_stall;
      logic [80:0] snap;
      int n;
      fill_mem();
      ready     = 1'b1;
      new_frame = 1'b1;
      tick;
      new_frame = 1'b0;
      n = 0;
      while (!valid_tri && n < 40) begin
         tick;
         n++;
      end
      n_cmp++;
      if (valid_tri !== 1'b1) begin
         n_err++;
         $display("FAIL stall_first_valid: got %b want 1 within 40 cycles", valid_tri);
      end
      snap = {vert1, vert2, vert3};
      n_cmp++;
      if (snap !== exp_tri(0)) begin
         n_err++;
         $display("FAIL stall_tri0: got %h want %h", snap, exp_tri(0));
      end
      tick;
      tick;
      ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         n_cmp++;
         if (valid_tri !== 1'b0 || {vert1, vert2, vert3} !== snap) begin
            n_err++;
            $display("FAIL stall_hold%0d: got valid %b verts %h want 0 %h", i, valid_tri,
                     {vert1, vert2, vert3}, snap);
         end
         tick;
      end
      ready = 1'b1;
      n = 0;
      while (!valid_tri && n < 40) begin
         tick;
         n++;
      end
      n_cmp++;
      if (valid_tri !== 1'b1 || obj_done !== 1'b1 || {vert1, vert2, vert3} !== exp_tri(1)) begin
         n_err++;
         $display("FAIL stall_tri1: got v%b o%b %h want v1 o1 %h", valid_tri, obj_done,
                  {vert1, vert2, vert3}, exp_tri(1));
      end
      n = 0;
      while (!frame_done && n < 40) begin
         tick;
         n++;
      end
      n_cmp++;
      if (frame_done !== 1'b1) begin
         n_err++;
         $display("FAIL stall_frame_done: got %b want 1 within 40 cycles", frame_done);
      end
      tick;
   endtask

   task automatic test_offer_stall;
      int n;
      int ntx;
      fill_mem();
      ready     = 1'b0;
      new_frame = 1'b1;
      tick;
      new_frame = 1'b0;
      n = 0;
      while (!valid_tri && n < 40) begin
         tick;
         n++;
      end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (valid_tri !== 1'b1 || {vert1, vert2, vert3} !== exp_tri(0)) begin
            n_err++;
            $display("FAIL offer_hold%0d: got valid %b verts %h want 1 %h", i, valid_tri,
                     {vert1, vert2, vert3}, exp_tri(0));
         end
         if (i < 7) tick;
      end
      ready = 1'b1;
      tick;
      n_cmp++;
      if (valid_tri !== 1'b0 || obj_done !== 1'b0) begin
         n_err++;
         $display("FAIL offer_after_xfer: got v%b o%b want v0 o0", valid_tri, obj_done);
      end
      ntx = 0;
      n   = 0;
      while (!frame_done && n < 60) begin
         if (valid_tri && ready) ntx++;
         tick;
         n++;
      end
      n_cmp++;
      if (frame_done !== 1'b1 || ntx != 1) begin
         n_err++;
         $display("FAIL offer_rest: got done %b transfers %0d want 1 1", frame_done, ntx);
      end
      tick;
   endtask

   task automatic test_new_frame_ignored;
      bit ok;
      fill_mem();
      run_frame(2, 7);
      ok = (obs_addr.size() == NW);
      for (int i = 0; i < obs_addr.size(); i++) if (obs_addr[i] != i) ok = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL nf_addr_seq: got %p want 0..%0d", obs_addr, NW - 1);
      end
      n_cmp++;
      if (obs_tri.size() != NT || obs_fd != 1) begin
         n_err++;
         $display("FAIL nf_counts: got %0d tris %0d done want %0d 1", obs_tri.size(), obs_fd, NT);
      end
      for (int t = 0; t < obs_tri.size() && t < int'(NT); t++) begin
         n_cmp++;
         if (obs_tri[t] !== exp_tri(t)) begin
            n_err++;
            $display("FAIL nf_tri%0d: got %h want %h", t, obs_tri[t], exp_tri(t));
         end
      end
   endtask

   task automatic test_reset_drain;
      fill_mem();
      ready     = 1'b1;
      new_frame = 1'b1;
      tick;
      new_frame = 1'b0;
      tick;
      tick;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      n_cmp++;
      if ({vert1, vert2, vert3, mem_addr, valid_tri, obj_done, busy, frame_done} !== '0) begin
         n_err++;
         $display("FAIL rst_drain_outputs: got %h want 0",
                  {vert1, vert2, vert3, mem_addr, valid_tri, obj_done, busy, frame_done});
      end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (valid_tri !== 1'b0 || busy !== 1'b0 || {vert1, vert2, vert3} !== '0) begin
            n_err++;
            $display("FAIL rst_drain_quiet%0d: got v%b b%b %h want 0", i, valid_tri, busy,
                     {vert1, vert2, vert3});
         end
         tick;
      end
      fill_mem();
      run_frame(-1, -1);
      n_cmp++;
      if (obs_addr.size() < 1 || obs_addr[0] != 0 || obs_addr.size() != NW) begin
         n_err++;
         $display("FAIL rst_restart_addr: got %p want 0..%0d", obs_addr, NW - 1);
      end
      for (int t = 0; t < obs_tri.size() && t < int'(NT); t++) begin
         n_cmp++;
         if (obs_tri[t] !== exp_tri(t)) begin
            n_err++;
            $display("FAIL rst_restart_tri%0d: got %h want %h", t, obs_tri[t], exp_tri(t));
         end
      end
      n_cmp++;
      if (obs_tri.size() != NT || obs_fd != 1) begin
         n_err++;
         $display("FAIL rst_restart_counts: got %0d tris %0d done want %0d 1", obs_tri.size(),
                  obs_fd, NT);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      new_frame = 1'b0;
      ready     = 1'b0;
      x_off     = '0;
      y_off     = '0;
      for (int i = 0; i < NW; i++) mem[i] = '0;
      test_reset();
      test_basic_frame();
      test_arith();
      test_stall();
      test_offer_stall();
      test_new_frame_ignored();
      test_reset_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
